clause_dispatch_arbiter: RTL and testbench
==========================================

Name: clause_dispatch_arbiter

Overview:
Parametrised, credit-based round-robin dispatcher: takes up to IN_WIDTH clauses per cycle from the clause fetch stage and distributes them to NUM_ENGINE BCP engines, at most one clause per engine per cycle. Engine occupancy is tracked with internal per-engine credit counters (one credit per engine input-FIFO slot). The block replaces registered-full-flag blocking, so an engine is never over-run even when it fills within a cycle. Sits between the clause fetch buffer and the engine input FIFOs.

Parameters:
NUM_ENGINE, 4, number of engines (power of two, >=2)
IN_WIDTH, 4, max clauses offered per cycle (1..NUM_ENGINE)
CLA_LENGTH, 3, literals per clause
VAR_WIDTH, 11, bits per literal
ENG_DEPTH, 4, engine input FIFO depth = initial credits per engine (>=1)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
start_in  in  1  level; dispatch enabled while high
engine_en_in  in  NUM_ENGINE  per-engine enable mask; 0 = skip engine
clause_in  in  IN_WIDTH x CLA_LENGTH*VAR_WIDTH  offered clauses, index 0 oldest
clause_cnt_in  in  $clog2(IN_WIDTH)+1  number of valid clauses in clause_in
credit_ret_in  in  NUM_ENGINE  1-cycle pulse per engine: one FIFO slot freed
clause_accept_out  out  $clog2(IN_WIDTH)+1  clauses consumed this cycle (combinational)
clause_out  out  NUM_ENGINE x CLA_LENGTH*VAR_WIDTH  registered clause per engine
grant_out  out  NUM_ENGINE  registered write strobe per engine
credit_out  out  NUM_ENGINE x $clog2(ENG_DEPTH)+1  current credit per engine
idle_out  out  1  all credits full and no grant in flight
overflow_err_out  out  1  sticky: credit return while credit == ENG_DEPTH

Behaviour:
- Reset: rr_ptr=0; every credit=ENG_DEPTH; grant_out=0; clause_out=0; overflow_err_out=0; state=IDLE; idle_out=1.
- FSM: IDLE -> RUN when start_in=1; RUN -> IDLE when start_in=0 (evaluated same cycle, no grants that cycle). No grants in IDLE; credit returns always processed.
- Effective count n = min(clause_cnt_in, IN_WIDTH).
- Selection (RUN, combinational): scan engines rr_ptr, rr_ptr+1, ... mod NUM_ENGINE, exactly one pass. Engine e eligible iff engine_en_in[e] && credit[e]>0. The k-th eligible engine visited (k<n) receives clause_in[k]. Scan stops after n assignments.
- clause_accept_out = assignments made; always a prefix of clause_in; upstream pops that many the same cycle.
- Grant latency: one cycle. grant_out[e]/clause_out[e] registered at the next edge; clause_out[e] holds last value when grant_out[e]=0.
- Credit per engine, next = credit - grant_now[e] + credit_ret_in[e]. A simultaneous grant and return leaves credit unchanged.
- Return at credit==ENG_DEPTH with no grant that cycle: credit saturates, overflow_err_out set until reset.
- Credit 0: engine skipped; it becomes eligible in the cycle after a return.
- rr_ptr update: if >=1 grant, rr_ptr = (last granted engine + 1) mod NUM_ENGINE; else unchanged. Wraps naturally.
- engine_en_in all 0 or n=0: no grants, accept=0, rr_ptr unchanged.
- idle_out = (state==IDLE or n==0) && all credit==ENG_DEPTH && grant_out==0.
- Reset mid-operation: in-flight registered grants dropped; credits restored to ENG_DEPTH. Engine FIFOs must be reset together with this block.

Decomposition:
- Package clause_pkg: LIT_IDX_MAX, VARIABLE_LENGTH, CLA_LENGTH, clause_t (packed CLA_LENGTH*VARIABLE_LENGTH), dispatch_state_e {IDLE, RUN}.
- Sub-module credit_counter: one per engine (generate). Handles dec/inc/saturate, overflow flag and has_credit output.

Test Plan:
- Reset then start_in=1, cnt=4, all enabled -> accept=4; next cycle grant_out=4'b1111, clause_out[e]=clause_in[e]; credits all 3; rr_ptr=0.
- cnt=2 from rr_ptr=0, then cnt=2 -> engines 0,1 then 2,3 granted; rr_ptr 2 then wraps to 0.
- credit[1]=0 (4 grants with no return), cnt=4 from ptr 0 -> accept=3; clause_in[0..2] go to engines 0,2,3; engine 1 skipped.
- Same-cycle grant and credit_ret on engine 2 at credit 2 -> credit stays 2. Extra return at credit 4 -> overflow_err_out=1 and sticky.
- engine_en_in=4'b0101, cnt=4 -> accept=2 to engines 0,2; start_in=0 -> accept=0 and no grants next cycle.
- Reset asserted while engine 3 credit=0 and grants are in flight -> next cycle grant_out=0, all credits 4, idle_out=1.

Source files
------------

// File: rtl/clause_pkg.sv
// Shared types and default clause geometry for the clause dispatch slice.
package clause_pkg;

    localparam int CLA_LENGTH      = 3;
    localparam int VARIABLE_LENGTH = 11;
    localparam int LIT_IDX_MAX     = CLA_LENGTH - 1;

    typedef logic [CLA_LENGTH*VARIABLE_LENGTH-1:0] clause_t;

    typedef enum logic {
        IDLE,
        RUN
    } dispatch_state_e;

endpackage

// File: rtl/clause_dispatch_arbiter_if.sv
// Bundle between the clause fetch stage, the dispatcher and the engine input FIFOs.
interface clause_dispatch_arbiter_if #(
    parameter int NUM_ENGINE = 4,
    parameter int IN_WIDTH   = 4,
    parameter int CLAUSE_W   = clause_pkg::CLA_LENGTH * clause_pkg::VARIABLE_LENGTH,
    parameter int ENG_DEPTH  = 4
);
    localparam int CNT_W    = $clog2(IN_WIDTH) + 1;
    localparam int CREDIT_W = $clog2(ENG_DEPTH) + 1;

    logic                                     start_in;
    logic [NUM_ENGINE-1:0]                    engine_en_in;
    logic [IN_WIDTH-1:0][CLAUSE_W-1:0]        clause_in;
    logic [CNT_W-1:0]                         clause_cnt_in;
    logic [NUM_ENGINE-1:0]                    credit_ret_in;
    logic [CNT_W-1:0]                         clause_accept_out;
    logic [NUM_ENGINE-1:0][CLAUSE_W-1:0]      clause_out;
    logic [NUM_ENGINE-1:0]                    grant_out;
    logic [NUM_ENGINE-1:0][CREDIT_W-1:0]      credit_out;
    logic                                     idle_out;
    logic                                     overflow_err_out;

    modport master (
        output start_in, engine_en_in, clause_in, clause_cnt_in, credit_ret_in,
        input  clause_accept_out, clause_out, grant_out, credit_out, idle_out, overflow_err_out
    );

    modport slave (
        input  start_in, engine_en_in, clause_in, clause_cnt_in, credit_ret_in,
        output clause_accept_out, clause_out, grant_out, credit_out, idle_out, overflow_err_out
    );

endinterface

// File: rtl/credit_counter.sv
// Per-engine credit counter: one credit per free slot in the engine input FIFO.
module credit_counter #(
    parameter  int ENG_DEPTH = 4,
    localparam int CREDIT_W  = $clog2(ENG_DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dec,
    input  logic                inc,
    output logic [CREDIT_W-1:0] credit,
    output logic                has_credit,
    output logic                full,
    output logic                overflow_err
);
    localparam logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(ENG_DEPTH);

    assign has_credit = (credit != '0);
    assign full       = (credit == MAX_CREDIT);

    // NOTE: sequential state uses non-blocking assignments so every counter
    // samples the same pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            credit       <= MAX_CREDIT;
            overflow_err <= 1'b0;
        end else begin
            unique case ({dec, inc})
                2'b10: credit <= credit - CREDIT_W'(1);
                2'b01: begin
                    // A return into a full counter is a protocol error; hold and flag it.
                    if (full) overflow_err <= 1'b1;
                    else      credit       <= credit + CREDIT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/clause_dispatch_arbiter.sv
// Credit-based round-robin dispatcher from the clause fetch buffer to the BCP engines.
module clause_dispatch_arbiter
    import clause_pkg::dispatch_state_e;
    import clause_pkg::IDLE;
    import clause_pkg::RUN;
#(
    parameter int NUM_ENGINE = 4,
    parameter int IN_WIDTH   = 4,
    parameter int CLA_LENGTH = clause_pkg::CLA_LENGTH,
    parameter int VAR_WIDTH  = clause_pkg::VARIABLE_LENGTH,
    parameter int ENG_DEPTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    clause_dispatch_arbiter_if.slave dif
);
    localparam int CLAUSE_W = CLA_LENGTH * VAR_WIDTH;
    localparam int CNT_W    = $clog2(IN_WIDTH) + 1;
    localparam int IDX_W    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int PTR_W    = $clog2(NUM_ENGINE);
    localparam int CREDIT_W = $clog2(ENG_DEPTH) + 1;

    dispatch_state_e                     state;
    logic [PTR_W-1:0]                    rr_ptr;
    logic [PTR_W-1:0]                    scan_eng;
    logic [PTR_W-1:0]                    last_eng;
    logic [CNT_W-1:0]                    n_eff;
    logic [CNT_W-1:0]                    accept;
    logic [NUM_ENGINE-1:0]               grant_now;
    logic [NUM_ENGINE-1:0][IDX_W-1:0]    sel_idx;
    logic [NUM_ENGINE-1:0]               has_credit;
    logic [NUM_ENGINE-1:0]               full;
    logic [NUM_ENGINE-1:0]               ovf;
    logic [NUM_ENGINE-1:0][CREDIT_W-1:0] credit;
    logic [NUM_ENGINE-1:0]               grant_q;
    logic [NUM_ENGINE-1:0][CLAUSE_W-1:0] clause_q;

    assign n_eff = (dif.clause_cnt_in > CNT_W'(IN_WIDTH)) ? CNT_W'(IN_WIDTH) : dif.clause_cnt_in;

    // One pass from rr_ptr: the k-th eligible engine takes clause_in[k].
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // through this block can infer a latch.
        grant_now = '0;
        sel_idx   = '0;
        accept    = '0;
        last_eng  = rr_ptr;
        scan_eng  = rr_ptr;
        if (state == RUN && dif.start_in) begin
            for (int i = 0; i < NUM_ENGINE; i++) begin
                scan_eng = rr_ptr + PTR_W'(i);
                if (dif.engine_en_in[scan_eng] && has_credit[scan_eng] && (accept < n_eff)) begin
                    grant_now[scan_eng] = 1'b1;
                    sel_idx[scan_eng]   = accept[IDX_W-1:0];
                    accept              = accept + CNT_W'(1);
                    last_eng            = scan_eng;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            // NOTE: the clause registers are reset too so the engine bus never
            // carries X, even though grant_q alone qualifies it.
            clause_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (dif.start_in)  state <= RUN;
                RUN:  if (!dif.start_in) state <= IDLE;
                default: state <= IDLE;
            endcase
            grant_q <= grant_now;
            if (|grant_now) rr_ptr <= last_eng + PTR_W'(1);
            for (int e = 0; e < NUM_ENGINE; e++) begin
                if (grant_now[e]) clause_q[e] <= dif.clause_in[sel_idx[e]];
            end
        end
    end

    for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_credit
        credit_counter #(.ENG_DEPTH(ENG_DEPTH)) u_credit (
            .clock        (clock),
            .reset        (reset),
            .dec          (grant_now[g]),
            .inc          (dif.credit_ret_in[g]),
            .credit       (credit[g]),
            .has_credit   (has_credit[g]),
            .full         (full[g]),
            .overflow_err (ovf[g])
        );
    end

    assign dif.clause_accept_out = accept;
    assign dif.grant_out         = grant_q;
    assign dif.clause_out        = clause_q;
    assign dif.credit_out        = credit;
    assign dif.overflow_err_out  = |ovf;
    assign dif.idle_out          = (state == IDLE || n_eff == '0) && (&full) && (grant_q == '0);

endmodule

// File: tb/tb_clause_dispatch_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic vs a queue model.
module tb_clause_dispatch_arbiter;
    import clause_pkg::*;

    localparam int NE  = 4;
    localparam int IW  = 4;
    localparam int DEP = 4;
    localparam int CW  = CLA_LENGTH * VARIABLE_LENGTH;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    clause_dispatch_arbiter_if #(.NUM_ENGINE(NE), .IN_WIDTH(IW), .CLAUSE_W(CW), .ENG_DEPTH(DEP)) dif ();

    clause_dispatch_arbiter #(
        .NUM_ENGINE (NE),
        .IN_WIDTH   (IW),
        .CLA_LENGTH (CLA_LENGTH),
        .VAR_WIDTH  (VARIABLE_LENGTH),
        .ENG_DEPTH  (DEP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .dif   (dif)
    );

    int n_checks;
    int n_fail;

    // Behavioural model state
    int          m_credit [NE];
    int          m_ptr;
    bit          m_run;
    bit          m_ovf;
    logic [NE-1:0] m_grant;
    clause_t     m_clause [NE];
    int          m_acc;
    int          m_last;
    logic [NE-1:0] m_gnow;
    int          m_src [NE];
    clause_t     cl [IW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_count();
        return (int'(dif.clause_cnt_in) > IW) ? IW : int'(dif.clause_cnt_in);
    endfunction

    // Eligible engines listed in visiting order; first n of them get clauses 0..n-1.
    function automatic void model_select();
        int order[$];
        int n;
        n      = eff_count();
        m_gnow = '0;
        m_acc  = 0;
        m_last = 0;
        if (!(m_run && dif.start_in)) return;
        for (int i = 0; i < NE; i++) begin
            int e;
            e = (m_ptr + i) % NE;
            if (dif.engine_en_in[e] && m_credit[e] > 0) order.push_back(e);
        end
        m_acc = (n < order.size()) ? n : order.size();
        for (int k = 0; k < m_acc; k++) begin
            m_gnow[order[k]] = 1'b1;
            m_src[order[k]]  = k;
            m_last           = order[k];
        end
    endfunction

    function automatic bit model_idle();
        bit all_full;
        all_full = 1'b1;
        for (int e = 0; e < NE; e++) if (m_credit[e] != DEP) all_full = 1'b0;
        return (!m_run || eff_count() == 0) && all_full && (m_grant == '0);
    endfunction

    function automatic void model_update();
        if (reset) begin
            for (int e = 0; e < NE; e++) begin
                m_credit[e] = DEP;
                m_clause[e] = '0;
            end
            m_ptr   = 0;
            m_run   = 1'b0;
            m_ovf   = 1'b0;
            m_grant = '0;
            return;
        end
        for (int e = 0; e < NE; e++) begin
            if (dif.credit_ret_in[e] && !m_gnow[e] && m_credit[e] == DEP) m_ovf = 1'b1;
            else m_credit[e] = m_credit[e] - int'(m_gnow[e]) + int'(dif.credit_ret_in[e]);
            if (m_gnow[e]) m_clause[e] = dif.clause_in[m_src[e]];
        end
        if (m_acc > 0) m_ptr = (m_last + 1) % NE;
        m_grant = m_gnow;
        m_run   = dif.start_in;
    endfunction

    task automatic drive(input bit rst, input bit st, input logic [NE-1:0] en,
                         input int cnt, input logic [NE-1:0] ret);
        clause_t c;
        reset             = rst;
        dif.start_in      = st;
        dif.engine_en_in  = en;
        dif.clause_cnt_in = 3'(cnt);
        dif.credit_ret_in = ret;
        for (int k = 0; k < IW; k++) begin
            c = clause_t'({$urandom(), $urandom()});
            cl[k] = c;
            dif.clause_in[k] = c;
        end
    endtask

    // Called at a negedge with inputs applied: checks combinational outputs,
    // advances one clock, then checks the registered outputs.
    task automatic tick();
        #1;
        if (!reset) begin
            model_select();
            check("accept", dif.clause_accept_out, 64'(m_acc));
            check("idle", dif.idle_out, 64'(model_idle()));
        end else begin
            m_gnow = '0;
            m_acc  = 0;
        end
        @(posedge clock);
        model_update();
        @(negedge clock);
        check("grant", dif.grant_out, 64'(m_grant));
        for (int e = 0; e < NE; e++) begin
            check($sformatf("clause_out[%0d]", e), dif.clause_out[e], 64'(m_clause[e]));
            check($sformatf("credit[%0d]", e), dif.credit_out[e], 64'(m_credit[e]));
        end
        check("overflow", dif.overflow_err_out, 64'(m_ovf));
    endtask

    initial begin
        logic [NE-1:0] r_en;
        logic [NE-1:0] r_ret;
        n_checks = 0;
        n_fail   = 0;

        // Reset state
        drive(1, 0, '0, 0, '0);
        @(negedge clock);
        tick();
        tick();
        check("rst_idle", dif.idle_out, 1);
        check("rst_grant", dif.grant_out, 0);
        check("rst_ovf", dif.overflow_err_out, 0);
        for (int e = 0; e < NE; e++) check($sformatf("rst_credit[%0d]", e), dif.credit_out[e], 4);

        // Full-width dispatch; first start cycle only moves IDLE -> RUN
        drive(0, 1, 4'hF, 4, '0);
        #1 check("t1_accept_idle", dif.clause_accept_out, 0);
        tick();
        drive(0, 1, 4'hF, 4, '0);
        #1 check("t1_accept", dif.clause_accept_out, 4);
        tick();
        check("t1_grant", dif.grant_out, 4'b1111);
        for (int e = 0; e < NE; e++) begin
            check($sformatf("t1_clause[%0d]", e), dif.clause_out[e], 64'(cl[e]));
            check($sformatf("t1_credit[%0d]", e), dif.credit_out[e], 3);
        end

        // Round-robin advance and wrap
        drive(0, 1, 4'hF, 0, 4'hF);
        tick();
        drive(0, 1, 4'hF, 2, '0);
        tick();
        check("t2_grant_a", dif.grant_out, 4'b0011);
        drive(0, 1, 4'hF, 2, '0);
        tick();
        check("t2_grant_b", dif.grant_out, 4'b1100);
        drive(0, 1, 4'hF, 1, '0);
        tick();
        check("t2_grant_wrap", dif.grant_out, 4'b0001);

        // Engine 1 out of credit is skipped
        drive(1, 0, '0, 0, '0);
        tick();
        drive(0, 1, 4'b0010, 1, '0);
        tick();
        repeat (4) begin
            drive(0, 1, 4'b0010, 1, '0);
            tick();
        end
        check("t3_credit1", dif.credit_out[1], 0);
        drive(0, 1, 4'b1000, 1, '0);
        tick();
        drive(0, 1, 4'hF, 4, '0);
        #1 check("t3_accept", dif.clause_accept_out, 3);
        tick();
        check("t3_grant", dif.grant_out, 4'b1101);
        check("t3_clause0", dif.clause_out[0], 64'(cl[0]));
        check("t3_clause2", dif.clause_out[2], 64'(cl[1]));
        check("t3_clause3", dif.clause_out[3], 64'(cl[2]));

        // Grant and return together, then overflow
        drive(0, 1, 4'b0100, 1, '0);
        tick();
        check("t4_credit2_pre", dif.credit_out[2], 2);
        drive(0, 1, 4'b0100, 1, 4'b0100);
        tick();
        check("t4_grant", dif.grant_out, 4'b0100);
        check("t4_credit2", dif.credit_out[2], 2);
        drive(0, 1, '0, 0, 4'b0001);
        tick();
        check("t4_no_ovf", dif.overflow_err_out, 0);
        drive(0, 1, '0, 0, 4'b0001);
        tick();
        check("t4_ovf", dif.overflow_err_out, 1);
        check("t4_credit0_sat", dif.credit_out[0], 4);
        drive(0, 1, '0, 0, '0);
        tick();
        check("t4_ovf_sticky", dif.overflow_err_out, 1);

        // Engine mask and stop
        drive(1, 0, '0, 0, '0);
        tick();
        drive(0, 1, 4'hF, 0, '0);
        tick();
        drive(0, 1, 4'b0101, 4, '0);
        #1 check("t5_accept", dif.clause_accept_out, 2);
        tick();
        check("t5_grant", dif.grant_out, 4'b0101);
        check("t5_clause0", dif.clause_out[0], 64'(cl[0]));
        check("t5_clause2", dif.clause_out[2], 64'(cl[1]));
        drive(0, 0, 4'hF, 4, '0);
        #1 check("t5_accept_stop", dif.clause_accept_out, 0);
        tick();
        check("t5_grant_stop", dif.grant_out, 0);

        // Reset with grants in flight
        drive(1, 0, '0, 0, '0);
        tick();
        drive(0, 1, 4'b1000, 1, '0);
        tick();
        repeat (4) begin
            drive(0, 1, 4'b1000, 1, '0);
            tick();
        end
        check("t6_credit3", dif.credit_out[3], 0);
        drive(0, 1, 4'hF, 4, '0);
        #1 check("t6_accept", dif.clause_accept_out, 3);
        tick();
        check("t6_grant_inflight", dif.grant_out, 4'b0111);
        drive(1, 1, 4'hF, 4, '0);
        tick();
        check("t6_grant", dif.grant_out, 0);
        check("t6_idle", dif.idle_out, 1);
        for (int e = 0; e < NE; e++) check($sformatf("t6_credit[%0d]", e), dif.credit_out[e], 4);

        // Random traffic against the model
        repeat (3000) begin
            r_en = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom());
            for (int e = 0; e < NE; e++)
                r_ret[e] = (m_credit[e] < DEP) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), r_en,
                  $urandom_range(0, 7), r_ret);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
